in_out_port: RTL and testbench

- Single router input/output port for a 2D mesh NoC.
- Receives fixed-length packets from upstream. A packet start is announced by a polarity toggle on a differential pair. The port buffers the packet, routes it from the header flit, and drives a one-hot crossbar select.
- Forwards the packet downstream under credit flow control, announced by its own differential-pair toggle.
- Returns one credit upstream per packet it frees.

---
 rtl/in_out_port.sv | 191 +++++++++++++++++++
 tb/tb_in_out_port.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/in_out_port.sv
// in_out_port: one 2D-mesh NoC router port. Buffers whole packets, routes them XY and forwards them under credits.
// Optional macro DIFF_PAIR_CHECK_EN: accept an upstream start toggle only when the input pair is complementary.
module in_out_port #(
  parameter int FLIT_W      = 32,
  parameter int PKT_FLITS   = 4,
  parameter int BUF_PKTS    = 2,
  parameter int LOCAL_X     = 0,
  parameter int LOCAL_Y     = 0,
  parameter int MAX_CREDITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              diff_pair_p_in,
  input  logic              diff_pair_n_in,
  input  logic [FLIT_W-1:0] input_channel,
  output logic [FLIT_W-1:0] data_out,
  input  logic              credit_in,
  output logic              diff_pair_p_out,
  output logic              diff_pair_n_out,
  output logic              crt_out,
  output logic [3:0]        xbar_cfg_vector
);

  localparam int DEPTH = BUF_PKTS * PKT_FLITS;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PKT_W = $clog2(BUF_PKTS + 1);
  localparam int FL_W  = $clog2(PKT_FLITS + 1);
  localparam int CR_W  = $clog2(MAX_CREDITS + 1);
  localparam logic [FL_W-1:0] LAST_FLIT = FL_W'(PKT_FLITS - 1);

  typedef enum logic {RX_IDLE, RX_BUSY} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_t;

  rx_state_t         rx_state;
  tx_state_t         tx_state;
  logic              p_ref;
  logic              rx_keep;
  logic              pair_ok;
  logic              toggle;
  logic              rx_start;
  logic              rx_admit;
  logic              rx_tail;
  logic              wr_en;
  logic              rd_en;
  logic              tx_start;
  logic [FL_W-1:0]   rx_cnt;
  logic [FL_W-1:0]   tx_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fill;
  logic [PKT_W-1:0]  pkts_ready;
  logic [CR_W-1:0]   credits;
  logic [FLIT_W-1:0] head_flit;
  logic [3:0]        head_route;
  logic [FLIT_W-1:0] mem [DEPTH];

  // XY dimension order; Y is a unidirectional ring so any Y mismatch goes Y+.
  function automatic logic [3:0] xy_route(input logic [7:0] dest);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [3:0] sel;
    dx = dest[7:4];
    dy = dest[3:0];
    if (dx > 4'(LOCAL_X))       sel = 4'b0001;
    else if (dx < 4'(LOCAL_X))  sel = 4'b0010;
    else if (dy != 4'(LOCAL_Y)) sel = 4'b0100;
    else                        sel = 4'b1000;
    return sel;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

`ifdef DIFF_PAIR_CHECK_EN
  assign pair_ok = (diff_pair_p_in != diff_pair_n_in);
`else
  logic unused_n_leg;
  assign unused_n_leg = diff_pair_n_in;
  assign pair_ok      = 1'b1;
`endif

  // Admission is decided on the header edge; the receiver is idle then, so fill is exact.
  always_comb begin
    toggle     = pair_ok && (diff_pair_p_in != p_ref);
    rx_start   = (rx_state == RX_IDLE) && toggle;
    rx_admit   = rx_start && ((CNT_W'(DEPTH) - fill) >= CNT_W'(PKT_FLITS));
    wr_en      = rx_admit || ((rx_state == RX_BUSY) && rx_keep);
    rx_tail    = (rx_state == RX_BUSY) && rx_keep && (rx_cnt == LAST_FLIT);
    head_flit  = mem[rd_ptr];
    head_route = (fill != '0) ? xy_route(head_flit[FLIT_W-1 -: 8]) : 4'b0000;
    tx_start   = (tx_state == TX_IDLE) && (pkts_ready != '0) &&
                 (xbar_cfg_vector != 4'b0000) && (credits != '0);
    rd_en      = tx_start || (tx_state == TX_SEND);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= input_channel;
  end

  // Receiver: a dropped packet still occupies the receiver so its body is not mistaken for a header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_keep  <= 1'b0;
      rx_cnt   <= '0;
      p_ref    <= 1'b1;
    end else begin
      if (pair_ok) p_ref <= diff_pair_p_in;
      case (rx_state)
        RX_IDLE: begin
          if (rx_start) begin
            rx_state <= RX_BUSY;
            rx_keep  <= rx_admit;
            rx_cnt   <= FL_W'(1);
          end
        end
        RX_BUSY: begin
          rx_cnt <= rx_cnt + FL_W'(1);
          if (rx_cnt == LAST_FLIT) rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // pkts_ready counts fully received packets not yet claimed by the transmitter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      pkts_ready <= '0;
      credits    <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      fill       <= fill + CNT_W'(wr_en) - CNT_W'(rd_en);
      pkts_ready <= pkts_ready + PKT_W'(rx_tail) - PKT_W'(tx_start);
      if (credit_in && !tx_start) begin
        if (credits != CR_W'(MAX_CREDITS)) credits <= credits + CR_W'(1);
      end else if (tx_start && !credit_in) begin
        credits <= credits - CR_W'(1);
      end
    end
  end

  // Transmitter: the route register only follows the FIFO head while no packet is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state        <= TX_IDLE;
      tx_cnt          <= '0;
      data_out        <= '0;
      crt_out         <= 1'b0;
      xbar_cfg_vector <= 4'b0000;
      diff_pair_p_out <= 1'b1;
      diff_pair_n_out <= 1'b0;
    end else begin
      crt_out <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          xbar_cfg_vector <= head_route;
          if (tx_start) begin
            data_out        <= head_flit;
            diff_pair_p_out <= ~diff_pair_p_out;
            diff_pair_n_out <= diff_pair_p_out;
            tx_cnt          <= FL_W'(1);
            tx_state        <= TX_SEND;
          end
        end
        TX_SEND: begin
          data_out <= head_flit;
          tx_cnt   <= tx_cnt + FL_W'(1);
          if (tx_cnt == LAST_FLIT) tx_state <= TX_DONE;
        end
        TX_DONE: begin
          data_out        <= '0;
          crt_out         <= 1'b1;
          xbar_cfg_vector <= head_route;
          tx_state        <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  a_xbar_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(xbar_cfg_vector));
  a_pair_compl:  assert property (@(posedge clk) disable iff (rst) diff_pair_p_out != diff_pair_n_out);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) fill <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_in_out_port.sv
// tb_in_out_port: directed plus random traffic into two ports (LOCAL 0,0 and LOCAL 2,1) sharing one stimulus,
// checked every cycle against a packet-level queue model.
module tb_in_out_port;

  localparam int PKT_FLITS   = 4;
  localparam int BUF_PKTS    = 2;
  localparam int MAX_CREDITS = 2;
  localparam int DEPTH       = BUF_PKTS * PKT_FLITS;

  typedef logic [PKT_FLITS-1:0][31:0] pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        diff_pair_p_in, diff_pair_n_in, credit_in;
  logic [31:0] input_channel;
  logic [31:0] data_out0, data_out1;
  logic        p_out0, n_out0, crt0, p_out1, n_out1, crt1;
  logic [3:0]  xbar0, xbar1;

  int tests = 0;
  int failures = 0;
  logic p_lvl;

  pkt_t        mq[$];
  int          mgot[$];
  pkt_t        m_tx_pkt;
  int          m_phase, m_credits, m_rx_left;
  bit          m_rx_keep;
  logic        m_ref, m_p, m_crt;
  logic [31:0] m_data;
  logic [3:0]  m_xbar0, m_xbar1;

  always #5 clk = ~clk;

  in_out_port #(.LOCAL_X(0), .LOCAL_Y(0)) u_dut0 (
    .clk(clk), .rst(rst), .diff_pair_p_in(diff_pair_p_in), .diff_pair_n_in(diff_pair_n_in),
    .input_channel(input_channel), .data_out(data_out0), .credit_in(credit_in),
    .diff_pair_p_out(p_out0), .diff_pair_n_out(n_out0), .crt_out(crt0), .xbar_cfg_vector(xbar0));

  in_out_port #(.LOCAL_X(2), .LOCAL_Y(1)) u_dut1 (
    .clk(clk), .rst(rst), .diff_pair_p_in(diff_pair_p_in), .diff_pair_n_in(diff_pair_n_in),
    .input_channel(input_channel), .data_out(data_out1), .credit_in(credit_in),
    .diff_pair_p_out(p_out1), .diff_pair_n_out(n_out1), .crt_out(crt1), .xbar_cfg_vector(xbar1));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_route(input logic [31:0] h, input int lx, input int ly);
    int dx, dy;
    dx = int'(h[31:28]);
    dy = int'(h[27:24]);
    if (dx > lx) return 4'b0001;
    if (dx < lx) return 4'b0010;
    if (dy != ly) return 4'b0100;
    return 4'b1000;
  endfunction

  task automatic model_reset();
    mq.delete();
    mgot.delete();
    m_phase = 0; m_credits = 0; m_rx_left = 0; m_rx_keep = 0;
    m_ref = 1'b1; m_p = 1'b1; m_crt = 1'b0; m_data = '0;
    m_xbar0 = '0; m_xbar1 = '0;
  endtask

  // One clock edge of the reference port, from its pre-edge state and the inputs held across the edge.
  task automatic model_edge();
    int stored, free_slots, last;
    logic [3:0] r0, r1;
    bit start, tog;
    pkt_t tmp;
    stored = 0;
    foreach (mgot[i]) stored += mgot[i];
    if (m_phase > 0 && m_phase < PKT_FLITS) stored += PKT_FLITS - m_phase;
    free_slots = DEPTH - stored;
    r0 = (mq.size() > 0) ? ref_route(mq[0][0], 0, 0) : 4'b0000;
    r1 = (mq.size() > 0) ? ref_route(mq[0][0], 2, 1) : 4'b0000;
    start = (m_phase == 0) && (mq.size() > 0) && (mgot[0] == PKT_FLITS) && (m_xbar0 != 0) && (m_credits > 0);
    m_crt = 1'b0;
    if (m_phase == 0) begin
      m_xbar0 = r0; m_xbar1 = r1;
      if (start) begin
        m_tx_pkt = mq.pop_front();
        mgot.delete(0);
        m_data = m_tx_pkt[0];
        m_p = ~m_p;
        m_phase = 1;
      end
    end else if (m_phase < PKT_FLITS) begin
      m_data = m_tx_pkt[m_phase];
      m_phase++;
    end else begin
      m_data = '0; m_crt = 1'b1; m_xbar0 = r0; m_xbar1 = r1; m_phase = 0;
    end
    if (start && !credit_in) m_credits--;
    else if (!start && credit_in && m_credits < MAX_CREDITS) m_credits++;
    tog = (diff_pair_p_in != m_ref);
    m_ref = diff_pair_p_in;
    if (m_rx_left == 0) begin
      if (tog) begin
        m_rx_keep = (free_slots >= PKT_FLITS);
        m_rx_left = PKT_FLITS - 1;
        if (m_rx_keep) begin
          tmp = '0;
          tmp[0] = input_channel;
          mq.push_back(tmp);
          mgot.push_back(1);
        end
      end
    end else begin
      if (m_rx_keep) begin
        last = mq.size() - 1;
        tmp = mq[last];
        tmp[mgot[last]] = input_channel;
        mq[last] = tmp;
        mgot[last] = mgot[last] + 1;
      end
      m_rx_left--;
    end
  endtask

  task automatic compare_all();
    checkOutput("data_out", data_out0, m_data);
    checkOutput("crt_out", {31'b0, crt0}, {31'b0, m_crt});
    checkOutput("xbar", {28'b0, xbar0}, {28'b0, m_xbar0});
    checkOutput("p_out", {31'b0, p_out0}, {31'b0, m_p});
    checkOutput("n_out", {31'b0, n_out0}, {31'b0, ~m_p});
    checkOutput("xbar_lx2", {28'b0, xbar1}, {28'b0, m_xbar1});
    checkOutput("data_out_lx2", data_out1, m_data);
    checkOutput("crt_out_lx2", {31'b0, crt1}, {31'b0, m_crt});
    checkOutput("p_out_lx2", {31'b0, p_out1}, {31'b0, m_p});
  endtask

  task automatic applyStimulus(input logic p, input logic [31:0] d, input logic c);
    diff_pair_p_in = p;
    diff_pair_n_in = ~p;
    input_channel  = d;
    credit_in      = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    p_lvl = 1'b1;
    diff_pair_p_in = 1'b1; diff_pair_n_in = 1'b0; credit_in = 1'b0; input_channel = '0;
    rst = 1'b1;
    #1;
    checkOutput("rst_data_out", data_out0, 32'h0);
    checkOutput("rst_crt_out", {31'b0, crt0}, 32'h0);
    checkOutput("rst_xbar", {28'b0, xbar0}, 32'h0);
    checkOutput("rst_p_out", {31'b0, p_out0}, 32'h1);
    checkOutput("rst_n_out", {31'b0, n_out0}, 32'h0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send_pkt(input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] f2, input logic [31:0] f3);
    p_lvl = ~p_lvl;
    applyStimulus(p_lvl, f0, 1'b0);
    applyStimulus(p_lvl, f1, 1'b0);
    applyStimulus(p_lvl, f2, 1'b0);
    applyStimulus(p_lvl, f3, 1'b0);
  endtask

  task automatic idle(input int n, input logic credit_first);
    for (int i = 0; i < n; i++) applyStimulus(p_lvl, 32'h0, (i == 0) ? credit_first : 1'b0);
  endtask

  initial begin
    int pulses, snd_idx;
    logic [31:0] d;
    logic c;
    rst = 1'b0;
    diff_pair_p_in = 1'b1; diff_pair_n_in = 1'b0; credit_in = 1'b0; input_channel = '0;
    model_reset();
    #2;
    do_reset(20);
    idle(2, 1'b0);

    // Basic packet held without credit, then released by one credit pulse.
    p_lvl = ~p_lvl;
    applyStimulus(p_lvl, 32'h1100_0000, 1'b0);
    applyStimulus(p_lvl, 32'h00FF_0000, 1'b0);
    checkOutput("hdr_route_xplus", {28'b0, xbar0}, 32'h1);
    checkOutput("hdr_route_xminus_lx2", {28'b0, xbar1}, 32'h2);
    applyStimulus(p_lvl, 32'h0000_FF00, 1'b0);
    applyStimulus(p_lvl, 32'h0000_00FF, 1'b0);
    idle(3, 1'b0);
    checkOutput("held_p_out", {31'b0, p_out0}, 32'h1);
    checkOutput("held_data", data_out0, 32'h0);
    checkOutput("held_xbar", {28'b0, xbar0}, 32'h1);
    applyStimulus(p_lvl, 32'h0, 1'b1);
    applyStimulus(p_lvl, 32'h0, 1'b0);
    checkOutput("tx_p_out", {31'b0, p_out0}, 32'h0);
    checkOutput("tx_n_out", {31'b0, n_out0}, 32'h1);
    checkOutput("tx_flit0", data_out0, 32'h1100_0000);
    applyStimulus(p_lvl, 32'h0, 1'b0);
    checkOutput("tx_flit1", data_out0, 32'h00FF_0000);
    applyStimulus(p_lvl, 32'h0, 1'b0);
    checkOutput("tx_flit2", data_out0, 32'h0000_FF00);
    applyStimulus(p_lvl, 32'h0, 1'b0);
    checkOutput("tx_flit3", data_out0, 32'h0000_00FF);
    applyStimulus(p_lvl, 32'h0, 1'b0);
    checkOutput("tx_end_data", data_out0, 32'h0);
    checkOutput("tx_end_xbar", {28'b0, xbar0}, 32'h0);
    checkOutput("tx_end_crt", {31'b0, crt0}, 32'h1);
    applyStimulus(p_lvl, 32'h0, 1'b0);
    checkOutput("crt_one_cycle", {31'b0, crt0}, 32'h0);

    // Local and Y+ routes.
    send_pkt(32'h00AB_CDEF, 32'h1, 32'h2, 32'h3);
    checkOutput("route_local", {28'b0, xbar0}, 32'h8);
    checkOutput("route_lx2_dx0", {28'b0, xbar1}, 32'h2);
    idle(8, 1'b1);
    send_pkt(32'h0123_4567, 32'h4, 32'h5, 32'h6);
    checkOutput("route_yplus", {28'b0, xbar0}, 32'h4);
    idle(8, 1'b1);
    send_pkt(32'h2100_0000, 32'h7, 32'h8, 32'h9);
    checkOutput("route_lx2_local", {28'b0, xbar1}, 32'h8);
    idle(8, 1'b1);

    // Three back-to-back packets into a two-packet buffer; the third must be dropped.
    send_pkt(32'h1000_0001, 32'hA1, 32'hA2, 32'hA3);
    send_pkt(32'h3000_0002, 32'hB1, 32'hB2, 32'hB3);
    send_pkt(32'h0000_0003, 32'hC1, 32'hC2, 32'hC3);
    idle(2, 1'b0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(p_lvl, 32'h0, (i < 2) ? 1'b1 : 1'b0);
      if (crt0 === 1'b1) pulses++;
    end
    checkOutput("drop_crt_pulses", pulses, 32'd2);
    checkOutput("drop_fifo_empty", {28'b0, xbar0}, 32'h0);

    // Reset in the middle of a transmission.
    send_pkt(32'h1200_0000, 32'hD1, 32'hD2, 32'hD3);
    applyStimulus(p_lvl, 32'h0, 1'b1);
    applyStimulus(p_lvl, 32'h0, 1'b0);
    applyStimulus(p_lvl, 32'h0, 1'b0);
    do_reset(2);
    idle(8, 1'b1);
    checkOutput("post_rst_xbar", {28'b0, xbar0}, 32'h0);
    checkOutput("post_rst_data", data_out0, 32'h0);

    // Random traffic with occasional spurious toggles mid-packet and one reset.
    snd_idx = -1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 900) begin
        do_reset(3);
        snd_idx = -1;
      end
      c = ($urandom_range(0, 5) == 0);
      d = $urandom;
      if (snd_idx < 0) begin
        if ($urandom_range(0, 2) == 0) begin
          p_lvl = ~p_lvl;
          d[31:28] = 4'($urandom_range(0, 3));
          d[27:24] = 4'($urandom_range(0, 3));
          snd_idx = 1;
        end
      end else begin
        if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
        snd_idx = (snd_idx == PKT_FLITS - 1) ? -1 : snd_idx + 1;
      end
      applyStimulus(p_lvl, d, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
